segmux_scan: RTL and testbench
==============================

# segmux_scan

Parametrised multiplexed hex display driver for common-anode or common-cathode seven-segment banks. It holds a `DIGITS`-nibble value and time-multiplexes it onto one shared segment bus with one digit-enable per digit. Each digit gets a fixed scan slot, and a dead-time at the start of each slot suppresses ghosting. It sits between register-mapped display data (for example the 8255 port latches) and the board's segment and digit pins, replacing the per-digit combinational decoders.

## Interface
- `DIGITS`, default 4: number of digits, legal range 1..8.
- `SCAN_DIV`, default 50000: clock cycles per digit slot, at least 2.
- `DEAD`, default 16: blanked cycles at the start of each slot, 0 ≤ `DEAD` < `SCAN_DIV`.
- `SEG_ACT_LOW`, default 0: when 1, `oSEG` and `oDP` are inverted at the pins.
- `DIG_ACT_LOW`, default 0: when 1, `oDIG` is inverted at the pins.
- `iCLK` input, 1 bit: the single clock; all logic on the rising edge.
- `iRST_N` input, 1 bit: asynchronous active-low reset.
- `iDATA` input, 4*`DIGITS` bits: digit k is `iDATA[4k+3:4k]`; digit 0 is least significant.
- `iDP` input, `DIGITS` bits: decimal point per digit.
- `iBLANK` input, 1 bit: synchronous display-off request.
- `oSEG` output, 7 bits: segments, bit0=a … bit6=g; logical 1 means lit.
- `oDP` output, 1 bit: decimal point of the active digit.
- `oDIG` output, `DIGITS` bits: one-hot digit enable; logical 1 means on.

## Operation
- **Counters.** Slot counter `cnt` has width `$clog2(SCAN_DIV)` and runs 0..`SCAN_DIV`-1. Digit index `idx` runs 0..`DIGITS`-1 and advances when `cnt`=`SCAN_DIV`-1, wrapping from `DIGITS`-1 to 0.
- **Snapshot.** `snap_data`/`snap_dp` load from `iDATA`/`iDP` on the frame-end cycle (`cnt`=`SCAN_DIV`-1 and `idx`=`DIGITS`-1). This keeps a whole frame coherent; input changes mid-frame are invisible until the next frame.
- **Hex decode.** Patterns, with a in bit0:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1100111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
  - Every one of the 16 codes decodes uniquely; there is no default path.
- **Output register, next edge:**
  - If `iBLANK`=1 or `cnt` < `DEAD`: `oDIG`=0, `oSEG`=0, `oDP`=0.
  - Otherwise: `oDIG`=onehot(`idx`), `oSEG`=decode(`snap_data[idx]`), `oDP`=`snap_dp[idx]`.
- **Polarity.** Inversion per `SEG_ACT_LOW`/`DIG_ACT_LOW` is applied after the output register; inactive means the logically-off level.
- **`iBLANK`.** Does not stop the counters or the snapshot.
- **`DIGITS`=1.** `idx` stays 0; the snapshot loads every slot end.

## Timing
- **Reset.** Asserting `iRST_N` low immediately forces `cnt`=0, `idx`=0, `snap_data`=0, `snap_dp`=0. Outputs go logically off: `oDIG`=0, `oSEG`=0, `oDP`=0 (pin levels per the polarity parameters).
- **Reset mid-scan.** Same behaviour; there is no partial-slot recovery.
- **Latency.** Outputs lag the counter state by 1 cycle. For digit k, `oDIG[k]` is active for exactly `SCAN_DIV`-`DEAD` cycles per frame.
- **Frame period.** `DIGITS`*`SCAN_DIV` cycles.
- **After reset release.** The first frame shows the reset snapshot (digit 0 shows "0"; higher digits show per LZB). New data appears in the frame that begins `DIGITS`*`SCAN_DIV` cycles after release.
- **Blanking.** Assertion or deassertion of `iBLANK` takes effect on the output 1 cycle later.
- **Simultaneous events.** Slot-end, frame-end and snapshot load happen on the same edge. The first output cycle of the new frame uses the new snapshot.

## Configuration
- `SEGMUX_LZB_EN` defined: leading-zero blanking.
  - Digits above the most significant non-zero nibble of `snap_data` show `oSEG`=0.
  - Their `oDIG` still scans, and their `oDP` still follows `snap_dp`.
  - Digit 0 is never blanked.
  - The blank mask is computed combinationally from the snapshot.
- Undefined: all digits always display, zeros included.

## Structure
- **Package `segmux_pkg`:**
  - the 16 segment pattern constants;
  - `SEG_OFF` = 7'b0000000;
  - a `seg7_t` typedef (7-bit logic).
- **Sub-module `seg_hex_dec`:** combinational 4-bit to `seg7_t` decoder using the package constants, instantiated once on the muxed nibble.

## Test plan
- **Reset values.** Hold `iRST_N` low with `DIG_ACT_LOW`=1 → `oDIG`=4'b1111 pins, `oSEG`=0. Release → nothing lit for `DEAD`+1 cycles.
- **Scan sequence.** `DIGITS`=4, `SCAN_DIV`=8, `DEAD`=2 → per slot, 2 cycles `oDIG`=0 then 6 cycles of onehot. Order is 0001, 0010, 0100, 1000, then wrap; frame = 32 cycles.
- **Hex decode.** `iDATA`=16'hFEDC loaded → digits 0..3 show 0111001, 1011110, 1111001, 1110001. `iDATA`=16'hBA98 → 1111111, 1100111, 1110111, 1111100.
- **Snapshot coherence.** Change `iDATA` from 16'h1234 to 16'h5678 while `idx`=1 → the rest of that frame shows 1234. The next frame shows 5678.
- **Leading-zero blanking.** With `SEGMUX_LZB_EN`, `iDATA`=16'h0070 → digits 3 and 2 have `oSEG`=0, digit 1 shows 0000111, digit 0 shows 0111111. `iDATA`=0 → only digit 0 is lit, showing "0". Without the macro → all four digits are lit.
- **`iBLANK` and reset mid-frame.** Assert `iBLANK` for 5 cycles mid-slot → `oDIG`=0 for those 5 cycles, delayed by 1 cycle, and scan timing is unchanged. Pull `iRST_N` low at `idx`=2 → outputs go off immediately, and the next scan restarts at digit 0.

Source files
------------

// File: rtl/segmux_pkg.sv
// ---------------------------------------------------------------------------
// segmux_pkg
// Shared types and constants for the multiplexed seven-segment driver.
//   seg7_t      : 7-bit segment vector, bit0 = a ... bit6 = g, 1 = lit
//   SEG_OFF     : all segments dark
//   SEG_HEX_0..F: hex glyph patterns
// ---------------------------------------------------------------------------
package segmux_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_OFF   = 7'b0000000;

  //                          gfedcba
  localparam seg7_t SEG_HEX_0 = 7'b0111111;
  localparam seg7_t SEG_HEX_1 = 7'b0000110;
  localparam seg7_t SEG_HEX_2 = 7'b1011011;
  localparam seg7_t SEG_HEX_3 = 7'b1001111;
  localparam seg7_t SEG_HEX_4 = 7'b1100110;
  localparam seg7_t SEG_HEX_5 = 7'b1101101;
  localparam seg7_t SEG_HEX_6 = 7'b1111101;
  localparam seg7_t SEG_HEX_7 = 7'b0000111;
  localparam seg7_t SEG_HEX_8 = 7'b1111111;
  localparam seg7_t SEG_HEX_9 = 7'b1100111;
  localparam seg7_t SEG_HEX_A = 7'b1110111;
  localparam seg7_t SEG_HEX_B = 7'b1111100;
  localparam seg7_t SEG_HEX_C = 7'b0111001;
  localparam seg7_t SEG_HEX_D = 7'b1011110;
  localparam seg7_t SEG_HEX_E = 7'b1111001;
  localparam seg7_t SEG_HEX_F = 7'b1110001;

endpackage

// File: rtl/seg_hex_dec.sv
// ---------------------------------------------------------------------------
// seg_hex_dec
// Combinational 4-bit hex to seven-segment decoder (logical polarity).
//   nibble : input  [3:0] hex digit
//   seg    : output seg7_t segment pattern, 1 = lit
// ---------------------------------------------------------------------------
module seg_hex_dec
  import segmux_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  // All 16 codes are enumerated, so the case is full without a default arm.
  always_comb begin
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/segmux_scan.sv
// ---------------------------------------------------------------------------
// segmux_scan
// Time-multiplexed hex display driver: scans DIGITS nibbles onto one shared
// segment bus with a one-hot digit enable, blanking the first DEAD cycles of
// every SCAN_DIV-cycle slot to suppress ghosting. Input data is snapshotted
// once per frame so each frame is coherent.
//
// Parameters: DIGITS (1..8), SCAN_DIV (>=2), DEAD (< SCAN_DIV),
//             SEG_ACT_LOW / DIG_ACT_LOW pin polarity inversion.
// Ports:
//   iCLK    : clock, rising edge
//   iRST_N  : asynchronous active-low reset
//   iDATA   : 4*DIGITS nibbles, digit 0 in the low nibble
//   iDP     : decimal point per digit
//   iBLANK  : synchronous display-off request (scan keeps running)
//   oSEG    : segments a..g (bit0 = a)
//   oDP     : decimal point of the active digit
//   oDIG    : one-hot digit enable
// Build option: define SEGMUX_LZB_EN for leading-zero blanking.
// ---------------------------------------------------------------------------
module segmux_scan
  import segmux_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD        = 16,
  parameter int SEG_ACT_LOW = 0,
  parameter int DIG_ACT_LOW = 0
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic [4*DIGITS-1:0]   iDATA,
  input  logic [DIGITS-1:0]     iDP,
  input  logic                  iBLANK,
  output logic [6:0]            oSEG,
  output logic                  oDP,
  output logic [DIGITS-1:0]     oDIG
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_C   = CNT_W'(DEAD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic             SEG_INV  = (SEG_ACT_LOW != 0);
  localparam logic             DIG_INV  = (DIG_ACT_LOW != 0);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_data_q, snap_data_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  seg7_t               seg_q, seg_d;
  logic                dp_q, dp_d;

  logic                slot_end;
  logic                frame_end;
  logic [3:0]          cur_nibble;
  seg7_t               dec_seg;
  logic                cur_lzb;

  assign slot_end   = (cnt_q == CNT_LAST);
  assign frame_end  = slot_end && (idx_q == IDX_LAST);
  assign cur_nibble = snap_data_q[{idx_q, 2'b00} +: 4];

  seg_hex_dec u_dec (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

`ifdef SEGMUX_LZB_EN
  // Digit k (k>0) is a leading zero when it and every nibble above it are 0.
  logic [DIGITS-1:0] lzb_mask;

  assign lzb_mask[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lzb
      assign lzb_mask[gi] = ~|snap_data_q[4*DIGITS-1:4*gi];
    end
  endgenerate

  assign cur_lzb = lzb_mask[idx_q];
`else
  assign cur_lzb = 1'b0;
`endif

  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    snap_data_d = snap_data_q;
    snap_dp_d   = snap_dp_q;
    dig_d       = '0;
    seg_d       = SEG_OFF;
    dp_d        = 1'b0;

    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Loading on the frame-end edge means the first cycle of the new frame
    // already sees the new snapshot.
    if (frame_end) begin
      snap_data_d = iDATA;
      snap_dp_d   = iDP;
    end

    if (!iBLANK && (cnt_q >= DEAD_C)) begin
      dig_d = DIGITS'(1) << idx_q;
      seg_d = cur_lzb ? SEG_OFF : dec_seg;
      dp_d  = snap_dp_q[idx_q];
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      snap_data_q <= '0;
      snap_dp_q   <= '0;
      dig_q       <= '0;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      snap_data_q <= snap_data_d;
      snap_dp_q   <= snap_dp_d;
      dig_q       <= dig_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  // Pin polarity is applied after the register so reset drives pins to the
  // logically-off level of each polarity.
  assign oSEG = seg_q ^ {7{SEG_INV}};
  assign oDP  = dp_q ^ SEG_INV;
  assign oDIG = dig_q ^ {DIGITS{DIG_INV}};

endmodule

// File: tb/tb_segmux_scan.sv
// ---------------------------------------------------------------------------
// tb_segmux_scan
// Self-checking bench for segmux_scan with DIGITS=4, SCAN_DIV=8, DEAD=2,
// segments active-high, digit enables active-low. A reference model derives
// the expected outputs from the number of clock edges since reset using
// division/modulo, plus a per-frame snapshot of the inputs.
// Honours SEGMUX_LZB_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_segmux_scan;

  localparam int D     = 4;
  localparam int SD    = 8;
  localparam int DT    = 2;
  localparam int FRAME = D * SD;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [15:0]   data  = '0;
  logic [3:0]    dp    = '0;
  logic          blank = 1'b0;
  logic [6:0]    seg;
  logic          dpo;
  logic [3:0]    dig;

  int n_vec = 0;
  int n_err = 0;

  segmux_scan #(
    .DIGITS      (D),
    .SCAN_DIV    (SD),
    .DEAD        (DT),
    .SEG_ACT_LOW (0),
    .DIG_ACT_LOW (1)
  ) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .iDATA  (data),
    .iDP    (dp),
    .iBLANK (blank),
    .oSEG   (seg),
    .oDP    (dpo),
    .oDIG   (dig)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------------ model
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'b0111111;  4'h1: r = 7'b0000110;
      4'h2: r = 7'b1011011;  4'h3: r = 7'b1001111;
      4'h4: r = 7'b1100110;  4'h5: r = 7'b1101101;
      4'h6: r = 7'b1111101;  4'h7: r = 7'b0000111;
      4'h8: r = 7'b1111111;  4'h9: r = 7'b1100111;
      4'hA: r = 7'b1110111;  4'hB: r = 7'b1111100;
      4'hC: r = 7'b0111001;  4'hD: r = 7'b1011110;
      4'hE: r = 7'b1111001;  default: r = 7'b1110001;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] ref_seg(input logic [15:0] s, input int k);
    logic [3:0] n;
    n = s[4*k +: 4];
`ifdef SEGMUX_LZB_EN
    if (k > 0 && (s >> (4*k)) == 16'h0) return 7'b0000000;
`endif
    return hex7(n);
  endfunction

  int          e_m      = 0;     // clock edges since reset release
  logic [15:0] snap_m   = '0;
  logic [3:0]  snapdp_m = '0;
  logic [3:0]  exp_dig  = '0;    // logical (1 = on)
  logic [6:0]  exp_seg  = '0;
  logic        exp_dp   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_m      <= 0;
      snap_m   <= '0;
      snapdp_m <= '0;
      exp_dig  <= '0;
      exp_seg  <= '0;
      exp_dp   <= 1'b0;
    end else begin
      if (blank || (e_m % SD) < DT) begin
        exp_dig <= '0;
        exp_seg <= '0;
        exp_dp  <= 1'b0;
      end else begin
        exp_dig <= 4'(1 << ((e_m / SD) % D));
        exp_seg <= ref_seg(snap_m, (e_m / SD) % D);
        exp_dp  <= snapdp_m[(e_m / SD) % D];
      end
      if ((e_m % FRAME) == FRAME - 1) begin
        snap_m   <= data;
        snapdp_m <= dp;
      end
      e_m <= e_m + 1;
    end
  end

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (dig !== 4'hF || seg !== 7'h00 || dpo !== 1'b0) begin
      n_err++;
      $display("FAIL reset_immediate dig=%b seg=%b dp=%b want dig=1111 seg=0000000 dp=0", dig, seg, dpo);
    end
    data = 16'hFFFF;
    dp   = 4'hF;
    repeat (3) begin
      @(negedge clk);
      n_vec++;
      if (dig !== 4'hF || seg !== 7'h00 || dpo !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold dig=%b seg=%b dp=%b want dig=1111 seg=0000000 dp=0", dig, seg, dpo);
      end
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (dig !== 4'hF) begin
      n_err++;
      $display("FAIL release_dark dig=%b want 1111", dig);
    end
    repeat (DT) begin
      @(negedge clk);
      n_vec++;
      if (dig !== 4'hF || seg !== 7'h00) begin
        n_err++;
        $display("FAIL release_dead dig=%b seg=%b want dig=1111 seg=0000000", dig, seg);
      end
    end
    @(negedge clk);
    n_vec++;
    if (dig !== 4'b1110 || seg !== 7'b0111111 || dpo !== 1'b0) begin
      n_err++;
      $display("FAIL first_digit dig=%b seg=%b dp=%b want dig=1110 seg=0111111 dp=0", dig, seg, dpo);
    end
    $display("test_reset done");
  endtask

  task automatic test_scan();
    int on_cnt[D];
    for (int k = 0; k < D; k++) on_cnt[k] = 0;
    data = 16'($urandom);
    dp   = 4'($urandom);
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      n_vec++;
      if (dig !== ~exp_dig || seg !== exp_seg || dpo !== exp_dp) begin
        n_err++;
        $display("FAIL scan_model t=%0t dig=%b seg=%b dp=%b want dig=%b seg=%b dp=%b",
                 $time, dig, seg, dpo, ~exp_dig, exp_seg, exp_dp);
      end
      for (int k = 0; k < D; k++) if (dig[k] === 1'b0) on_cnt[k]++;
    end
    for (int k = 0; k < D; k++) begin
      n_vec++;
      if (on_cnt[k] != 2 * (SD - DT)) begin
        n_err++;
        $display("FAIL scan_on_time digit=%0d got %0d cycles want %0d", k, on_cnt[k], 2 * (SD - DT));
      end
    end
    $display("test_scan done");
  endtask

  // Hold a value for two frames, then check each digit's glyph for a frame.
  task automatic test_hex_value(input logic [15:0] v, input logic [27:0] want);
    int act;
    data = v;
    repeat (2 * FRAME) @(negedge clk);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      act = -1;
      for (int k = 0; k < D; k++) if (dig[k] === 1'b0) act = k;
      if (act >= 0) begin
        n_vec++;
        if (seg !== want[7*act +: 7]) begin
          n_err++;
          $display("FAIL hex_%h digit=%0d seg=%b want %b", v, act, seg, want[7*act +: 7]);
        end
      end
    end
  endtask

  task automatic test_hex();
    test_hex_value(16'hFEDC, {7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001});
    test_hex_value(16'hBA98, {7'b1111100, 7'b1110111, 7'b1100111, 7'b1111111});
    $display("test_hex done");
  endtask

  task automatic test_lzb();
`ifdef SEGMUX_LZB_EN
    test_hex_value(16'h0070, {7'b0000000, 7'b0000000, 7'b0000111, 7'b0111111});
    test_hex_value(16'h0000, {7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111});
`else
    test_hex_value(16'h0070, {7'b0111111, 7'b0111111, 7'b0000111, 7'b0111111});
    test_hex_value(16'h0000, {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111});
`endif
    $display("test_lzb done");
  endtask

  task automatic test_coherence();
    logic [15:0] vold, vnew;
    int act;
    int phase;
    vold = 16'h1234;
    vnew = 16'h5678;
    data = vold;
    repeat (2 * FRAME) @(negedge clk);
    for (int i = 0; i < 2 * FRAME && (e_m % FRAME) != SD + 3; i++) @(negedge clk);
    n_vec++;
    if ((e_m % FRAME) != SD + 3) begin
      n_err++;
      $display("FAIL coherence_wait timeout pos=%0d want %0d", e_m % FRAME, SD + 3);
    end
    data  = vnew;
    phase = 0;
    for (int c = 0; c < 56; c++) begin
      @(negedge clk);
      act = -1;
      for (int k = 0; k < D; k++) if (dig[k] === 1'b0) act = k;
      if (act == 0) phase = 1;
      if (act >= 0) begin
        n_vec++;
        if (seg !== hex7(phase ? vnew[4*act +: 4] : vold[4*act +: 4])) begin
          n_err++;
          $display("FAIL coherence frame=%0d digit=%0d seg=%b want %b", phase, act, seg,
                   hex7(phase ? vnew[4*act +: 4] : vold[4*act +: 4]));
        end
      end
    end
    n_vec++;
    if (phase != 1) begin
      n_err++;
      $display("FAIL coherence_frame got phase %0d want 1", phase);
    end
    $display("test_coherence done");
  endtask

  task automatic test_blank();
    for (int i = 0; i < 2 * SD && (e_m % SD) != DT; i++) @(negedge clk);
    n_vec++;
    if ((e_m % SD) != DT) begin
      n_err++;
      $display("FAIL blank_wait timeout cnt=%0d want %0d", e_m % SD, DT);
    end
    blank = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_vec++;
      if (dig !== 4'hF || seg !== 7'h00 || dpo !== 1'b0) begin
        n_err++;
        $display("FAIL blank_on dig=%b seg=%b dp=%b want dig=1111 seg=0000000 dp=0", dig, seg, dpo);
      end
    end
    blank = 1'b0;
    for (int c = 0; c < 2 * SD; c++) begin
      @(negedge clk);
      n_vec++;
      if (dig !== ~exp_dig || seg !== exp_seg || dpo !== exp_dp) begin
        n_err++;
        $display("FAIL blank_after t=%0t dig=%b seg=%b dp=%b want dig=%b seg=%b dp=%b",
                 $time, dig, seg, dpo, ~exp_dig, exp_seg, exp_dp);
      end
      if (c == 0) begin
        n_vec++;
        if (dig === 4'hF) begin
          n_err++;
          $display("FAIL blank_release dig=%b want a lit digit", dig);
        end
      end
    end
    $display("test_blank done");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2 * FRAME && (e_m % FRAME) != 2 * SD + 4; i++) @(negedge clk);
    n_vec++;
    if ((e_m % FRAME) != 2 * SD + 4) begin
      n_err++;
      $display("FAIL reset_mid_wait timeout pos=%0d want %0d", e_m % FRAME, 2 * SD + 4);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (dig !== 4'hF || seg !== 7'h00 || dpo !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_off dig=%b seg=%b dp=%b want dig=1111 seg=0000000 dp=0", dig, seg, dpo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DT) begin
      @(negedge clk);
      n_vec++;
      if (dig !== 4'hF) begin
        n_err++;
        $display("FAIL reset_mid_dead dig=%b want 1111", dig);
      end
    end
    @(negedge clk);
    n_vec++;
    if (dig !== 4'b1110 || seg !== 7'b0111111) begin
      n_err++;
      $display("FAIL reset_mid_restart dig=%b seg=%b want dig=1110 seg=0111111", dig, seg);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      n_vec++;
      if (dig !== ~exp_dig || seg !== exp_seg || dpo !== exp_dp) begin
        n_err++;
        $display("FAIL random t=%0t dig=%b seg=%b dp=%b want dig=%b seg=%b dp=%b",
                 $time, dig, seg, dpo, ~exp_dig, exp_seg, exp_dp);
      end
      blank = ($urandom_range(9) == 0);
      if ($urandom_range(5) == 0) begin
        // Bias towards leading zeros so blanking paths get exercised.
        data = 16'($urandom) >> (4 * $urandom_range(4));
        dp   = 4'($urandom);
      end
    end
    blank = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hex();
    test_lzb();
    test_coherence();
    test_blank();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
